// File: rtl/sa3_pkg.sv
// Shared types and constants for the 3x3 systolic operand loader.
// Slot numbering: filter bytes occupy slots 0..8, tile bytes 9..24.
package sa3_pkg;

  localparam int DATA_W = 8;
  localparam int N_B    = 9;
  localparam int N_A    = 16;
  localparam int N_TOT  = N_B + N_A;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] SLOT_B11  = 5'd0;
  localparam logic [CNT_W-1:0] SLOT_B33  = 5'd8;
  localparam logic [CNT_W-1:0] SLOT_A11  = 5'd9;
  localparam logic [CNT_W-1:0] SLOT_LAST = 5'd24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // A reuse request only skips the filter when one has been loaded since reset.
  function automatic logic [CNT_W-1:0] first_slot(input logic keep, input logic filt_ok);
    return (keep && filt_ok) ? SLOT_A11 : SLOT_B11;
  endfunction

endpackage

// File: rtl/sa3_operand_regs.sv
// 25-entry operand register file with a single indexed write port.
// All entries are visible at once on a flat bus, slot 0 in the low byte.
module sa3_operand_regs
  import sa3_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CNT_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  output logic [N_TOT*DATA_W-1:0] ops
);

  genvar gi;
  generate
    for (gi = 0; gi < N_TOT; gi++) begin : g_slot
      logic [DATA_W-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_reg <= '0;
        end else if (wr_en && (wr_idx == CNT_W'(gi))) begin
          slot_reg <= wr_data;
        end
      end

      assign ops[gi*DATA_W +: DATA_W] = slot_reg;
    end
  endgenerate

endmodule

// File: rtl/sa3_operand_loader.sv
// Streams a 3x3 filter and 4x4 tile into parallel operand registers, then
// runs the systolic array until it reports completion.
module sa3_operand_loader
  import sa3_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              keep_filter,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              active_sa3,
  input  logic              done_sa3,
  output logic [DATA_W-1:0] a11, a12, a13, a14,
  output logic [DATA_W-1:0] a21, a22, a23, a24,
  output logic [DATA_W-1:0] a31, a32, a33, a34,
  output logic [DATA_W-1:0] a41, a42, a43, a44,
  output logic [DATA_W-1:0] b11, b12, b13,
  output logic [DATA_W-1:0] b21, b22, b23,
  output logic [DATA_W-1:0] b31, b32, b33,
  output logic              busy,
  output logic              op_done
);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    filt_ok_reg;
  logic                    active_reg;
  logic                    op_done_reg;
  logic                    accept;
  logic [N_TOT*DATA_W-1:0] ops;

  assign accept = (state_reg == LOAD) && in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (accept && (cnt_reg == SLOT_LAST)) state_next = RUN;
      RUN:     if (done_sa3) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == LOAD);
    busy     = (state_reg != IDLE);
  end

  // active_sa3 follows the next state so it drops the cycle after done_sa3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      filt_ok_reg <= 1'b0;
      active_reg  <= 1'b0;
      op_done_reg <= 1'b0;
    end else begin
      active_reg  <= (state_next == RUN);
      op_done_reg <= (state_reg == RUN) && done_sa3;
      if ((state_reg == IDLE) && start) begin
        cnt_reg <= first_slot(keep_filter, filt_ok_reg);
      end else if (accept && (cnt_reg != SLOT_LAST)) begin
        cnt_reg <= cnt_reg + 5'd1;
      end
      if (accept && (cnt_reg == SLOT_B33)) begin
        filt_ok_reg <= 1'b1;
      end
    end
  end

  assign active_sa3 = active_reg;
  assign op_done    = op_done_reg;

  sa3_operand_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_idx  (cnt_reg),
    .wr_data (in_data),
    .ops     (ops)
  );

  assign b11 = ops[ 0*DATA_W +: DATA_W];
  assign b12 = ops[ 1*DATA_W +: DATA_W];
  assign b13 = ops[ 2*DATA_W +: DATA_W];
  assign b21 = ops[ 3*DATA_W +: DATA_W];
  assign b22 = ops[ 4*DATA_W +: DATA_W];
  assign b23 = ops[ 5*DATA_W +: DATA_W];
  assign b31 = ops[ 6*DATA_W +: DATA_W];
  assign b32 = ops[ 7*DATA_W +: DATA_W];
  assign b33 = ops[ 8*DATA_W +: DATA_W];
  assign a11 = ops[ 9*DATA_W +: DATA_W];
  assign a12 = ops[10*DATA_W +: DATA_W];
  assign a13 = ops[11*DATA_W +: DATA_W];
  assign a14 = ops[12*DATA_W +: DATA_W];
  assign a21 = ops[13*DATA_W +: DATA_W];
  assign a22 = ops[14*DATA_W +: DATA_W];
  assign a23 = ops[15*DATA_W +: DATA_W];
  assign a24 = ops[16*DATA_W +: DATA_W];
  assign a31 = ops[17*DATA_W +: DATA_W];
  assign a32 = ops[18*DATA_W +: DATA_W];
  assign a33 = ops[19*DATA_W +: DATA_W];
  assign a34 = ops[20*DATA_W +: DATA_W];
  assign a41 = ops[21*DATA_W +: DATA_W];
  assign a42 = ops[22*DATA_W +: DATA_W];
  assign a43 = ops[23*DATA_W +: DATA_W];
  assign a44 = ops[24*DATA_W +: DATA_W];

endmodule

// File: tb/tb_sa3_operand_loader.sv
// Scoreboard bench for sa3_operand_loader: loads are modelled as whole
// transactions and checked when the array run is enabled and released.
module tb_sa3_operand_loader;
  import sa3_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       keep_filter = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       done_sa3 = 1'b0;
  logic       in_ready, active_sa3, busy, op_done;
  logic [7:0] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [7:0] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [7:0] b11, b12, b13, b21, b22, b23, b31, b32, b33;

  sa3_operand_loader dut (
    .clk(clk), .rst(rst), .start(start), .keep_filter(keep_filter),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .active_sa3(active_sa3), .done_sa3(done_sa3),
    .a11(a11), .a12(a12), .a13(a13), .a14(a14),
    .a21(a21), .a22(a22), .a23(a23), .a24(a24),
    .a31(a31), .a32(a32), .a33(a33), .a34(a34),
    .a41(a41), .a42(a42), .a43(a43), .a44(a44),
    .b11(b11), .b12(b12), .b13(b13),
    .b21(b21), .b22(b22), .b23(b23),
    .b31(b31), .b32(b32), .b33(b33),
    .busy(busy), .op_done(op_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [24:0][7:0] dut_ops;
  assign dut_ops = {a44, a43, a42, a41, a34, a33, a32, a31, a24, a23, a22, a21,
                    a14, a13, a12, a11, b33, b32, b31, b23, b22, b21, b13, b12, b11};

  typedef struct {
    logic [24:0][7:0] ops;
    int               rise_cyc;
    int               ready_cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: operand image and whether a filter exists since reset.
  logic [24:0][7:0] m_ops = '0;
  bit               m_filt_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_ops(input string tag, input logic [24:0][7:0] exp);
    for (int i = 0; i < 25; i++)
      chk($sformatf("%s_slot%0d", tag, i), 32'(dut_ops[i]), 32'(exp[i]));
  endtask

  // Monitor: pops an expectation on each rising active_sa3.
  exp_t cur;
  bit   have_cur = 1'b0;
  int   ready_cnt = 0;
  bit   prev_active = 1'b0;
  bit   exp_op = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      ready_cnt   = 0;
      prev_active = 1'b0;
      exp_op      = 1'b0;
      have_cur    = 1'b0;
    end else begin
      chk("op_done", 32'(op_done), 32'(exp_op));
      if (exp_op) chk("active_fall", 32'(active_sa3), 0);
      if (in_ready) ready_cnt++;
      if (active_sa3 && !prev_active) begin
        if (sb.size() == 0) begin
          chk("active_unexpected", 32'(active_sa3), 0);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          chk("rise_cycle", 32'(cyc), 32'(cur.rise_cyc));
          chk("ready_cycles", 32'(ready_cnt), 32'(cur.ready_cnt));
          cmp_ops("run", cur.ops);
          $display("load done at cycle %0d: ready_cycles=%0d b11=%0d a11=%0d a44=%0d",
                   cyc, ready_cnt, b11, a11, a44);
        end
        ready_cnt = 0;
      end else if (sb.size() > 0 && cyc > sb[0].rise_cyc) begin
        checks++;
        errors++;
        $display("FAIL active_timeout actual=%0d required=1 at cycle %0d", active_sa3, sb[0].rise_cyc);
        void'(sb.pop_front());
        ready_cnt = 0;
      end
      if (!active_sa3 && prev_active && have_cur) begin
        cmp_ops("frozen", cur.ops);
        chk("busy_after_run", 32'(busy), 0);
        have_cur = 1'b0;
      end
      exp_op = active_sa3 && done_sa3;
      prev_active = active_sa3;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: gapless, 1: valid toggles 1/0, 2: random gaps with stray done_sa3
  task automatic run_load(input bit keep, input int mode, input bit det, input int base);
    int first, nbytes, sent, c, len;
    bit vq[$];
    logic [7:0] dq[$];
    exp_t e;
    first  = (keep && m_filt_ok) ? 9 : 0;
    nbytes = 25 - first;
    sent = 0;
    while (sent < nbytes) begin
      bit v;
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (vq.size() % 2) == 0;
      else v = $urandom_range(0, 3) != 0;
      vq.push_back(v);
      if (v) begin
        dq.push_back(det ? 8'(base + sent) : 8'($urandom));
        m_ops[first + sent] = dq[sent];
        sent++;
      end
    end
    len = vq.size();
    if (first == 0) m_filt_ok = 1'b1;
    for (int i = 0, n = $urandom_range(0, 2); i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      done_sa3 = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    done_sa3 = 1'b0;
    c = cyc;
    e.ops = m_ops;
    e.rise_cyc = c + len + 1;
    e.ready_cnt = len;
    sb.push_back(e);
    start = 1'b1;
    keep_filter = keep;
    tick();
    start = 1'b0;
    keep_filter = 1'($urandom_range(0, 1));
    sent = 0;
    for (int i = 0; i < len; i++) begin
      in_valid = vq[i];
      in_data  = vq[i] ? dq[sent] : 8'($urandom);
      done_sa3 = !vq[i] && mode == 2 && $urandom_range(0, 3) == 0;
      if (vq[i]) sent++;
      tick();
    end
    in_valid = 1'b0;
    done_sa3 = 1'b0;
  endtask

  // Array run: stray start/in_valid while RUN, then a done_sa3 pulse.
  task automatic run_phase();
    int r;
    r = $urandom_range(0, 3);
    for (int i = 0; i < r; i++) begin
      start       = (i == 0);
      keep_filter = 1'($urandom_range(0, 1));
      in_valid    = 1'b1;
      in_data     = 8'($urandom);
      tick();
    end
    start    = 1'b0;
    in_valid = 1'b0;
    done_sa3 = 1'b1;
    tick();
    done_sa3 = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_active"}, 32'(active_sa3), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_op_done"}, 32'(op_done), 0);
    cmp_ops(tag, '0);
  endtask

  initial begin
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    run_load(1'b1, 0, 1'b1, 1);   // keep_filter ignored straight after reset
    run_phase();
    run_load(1'b0, 1, 1'b1, 1);   // stalled stream
    run_phase();
    run_load(1'b1, 0, 1'b1, 100); // filter reuse
    run_phase();

    // Reset after 12 bytes of a full load.
    start = 1'b1;
    keep_filter = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(200 + i);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    m_ops = '0;
    m_filt_ok = 1'b0;
    $display("reset applied mid-load at cycle %0d", cyc);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();

    run_load(1'b1, 0, 1'b1, 1);   // full load needed again
    run_phase();

    for (int n = 0; n < 20; n++) begin
      run_load(1'($urandom_range(0, 1)), 2, 1'b0, 0);
      run_phase();
    end

    repeat (5) tick();
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
